// File: rtl/score_controller.sv
// Game-phase sequencer for the Flappy Bird score display: BCD score with ripple carry,
// best-score tracking, blink on game over, and active-low 7-segment drive per digit.
module score_controller #(
  parameter int NUM_DIGITS   = 3,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pass,
  input  logic                    crash,
  output logic                    active,
  output logic                    game_over,
  output logic                    new_best,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int TW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BLINK_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit 0 (ones) occupies the low nibble, so a plain unsigned compare of the
  // packed vector is the same as a BCD compare from the most significant digit down.
  typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;

  state_t        state;
  bcd_t          score;
  bcd_t          best;
  bcd_t          score_inc;
  bcd_t          display;
  logic          pass_q;
  logic          pass_rise;
  logic          blank;
  logic [TW-1:0] timer;

  function automatic bcd_t bcd_increment(input bcd_t v);
    bcd_t r;
    logic carry;
    logic all_nines;
    r         = v;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i] != 4'd9) all_nines = 1'b0;
    end
    if (!all_nines) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          if (v[i] == 4'd9) begin
            r[i] = 4'd0;
          end else begin
            r[i]  = v[i] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign pass_rise = pass & ~pass_q;
  assign score_inc = bcd_increment(score);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      score     <= '0;
      best      <= '0;
      pass_q    <= 1'b0;
      timer     <= '0;
      blank     <= 1'b0;
      new_best  <= 1'b0;
      active    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      pass_q   <= pass;
      new_best <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= PLAY;
            score  <= '0;
            active <= 1'b1;
          end
        end
        PLAY: begin
          // Crash wins over a same-edge pass; the score is frozen as it stood.
          if (crash) begin
            state     <= OVER;
            active    <= 1'b0;
            game_over <= 1'b1;
            timer     <= '0;
            blank     <= 1'b0;
            if (score > best) begin
              best     <= score;
              new_best <= 1'b1;
            end
          end else if (pass_rise) begin
            score <= score_inc;
          end
        end
        OVER: begin
          if (start) begin
            state     <= PLAY;
            score     <= '0;
            blank     <= 1'b0;
            timer     <= '0;
            active    <= 1'b1;
            game_over <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            timer <= '0;
            blank <= ~blank;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          active    <= 1'b0;
          game_over <= 1'b0;
          blank     <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // through it can infer a latch.
  always_comb begin
    display = score;
    hex_out = '1;
    if (state == IDLE) display = best;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_out[7*i +: 7] = (state == OVER && blank) ? SEG_BLANK : seg7(display[i]);
    end
  end

endmodule
